// File: rtl/axil_led_pkg.sv
// Shared definitions for the AXI-Lite LED controller: register map, CTRL fields,
// response codes and the byte-lane merge helper.
package axil_led_pkg;

  typedef enum logic [1:0] {
    REG_CTRL    = 2'd0,
    REG_PERIOD  = 2'd1,
    REG_PATTERN = 2'd2,
    REG_STATUS  = 2'd3
  } reg_idx_t;

  localparam int         CTRL_EN     = 0;
  localparam int         CTRL_MODE   = 1;
  localparam logic       MODE_BLINK  = 1'b0;
  localparam logic       MODE_ROTATE = 1'b1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;

  // Merge write data into a register value one byte lane at a time.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old,
                                               input logic [31:0] data,
                                               input logic [3:0]  strb);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[b*8 +: 8] = data[b*8 +: 8];
      end else begin
        res[b*8 +: 8] = old[b*8 +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/led_tick_engine.sv
// Free-running tick engine: divides the clock by the half-period and drives the
// LEDs in blink or rotate mode. A start (enable rise or restart) beats a tick.
module led_tick_engine
  import axil_led_pkg::*;
#(
  parameter int N_LEDS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic [31:0]       period,
  input  logic [N_LEDS-1:0] pattern,
  input  logic              restart,
  output logic [N_LEDS-1:0] leds,
  output logic [15:0]       tick_count
);

  localparam int WRAP_SHIFT = N_LEDS - 1;

  logic              en_d;
  logic              phase;
  logic [31:0]       count;
  logic [31:0]       limit;
  logic              start;
  logic              tick;
  logic [N_LEDS-1:0] rotated;

  assign limit   = (period == 32'd0) ? 32'd0 : period - 32'd1;
  assign start   = en & (~en_d | restart);
  assign tick    = en & ~start & (count == limit);
  assign rotated = (leds << 1'b1) | (leds >> WRAP_SHIFT);

  // Counter, phase, LED state and tick count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_d       <= 1'b0;
      phase      <= 1'b0;
      count      <= 32'd0;
      leds       <= {N_LEDS{1'b0}};
      tick_count <= 16'd0;
    end else begin
      en_d <= en;
      if (!en) begin
        count <= 32'd0;
        phase <= 1'b0;
        leds  <= {N_LEDS{1'b0}};
      end else if (start) begin
        count <= 32'd0;
        phase <= 1'b1;
        leds  <= pattern;
      end else if (tick) begin
        count      <= 32'd0;
        tick_count <= tick_count + 16'd1;
        if (mode == MODE_ROTATE) begin
          leds <= rotated;
        end else begin
          phase <= ~phase;
          leds  <= phase ? {N_LEDS{1'b0}} : pattern;
        end
      end else begin
        count <= count + 32'd1;
      end
    end
  end

endmodule

// File: rtl/axil_led_ctrl.sv
// AXI4-Lite register block for the board LEDs: CTRL/PERIOD/PATTERN/STATUS
// registers plus the tick engine that sequences the outputs.
module axil_led_ctrl
  import axil_led_pkg::*;
#(
  parameter int          N_LEDS         = 8,
  parameter int          ADDR_WIDTH     = 40,
  parameter logic [31:0] DEFAULT_PERIOD = 32'd50_000_000
) (
  input  logic                  pl_sys_clk,
  input  logic                  axil_rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [31:0]           s_axil_wdata,
  input  logic [3:0]            s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [31:0]           s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [N_LEDS-1:0]     leds
);

  logic              aw_held;
  logic              w_held;
  reg_idx_t          aw_idx;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              aw_hs;
  logic              w_hs;
  logic              ar_hs;
  logic              wr_fire;
  reg_idx_t          wr_idx;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic              en;
  logic              mode;
  logic [31:0]       period;
  logic [N_LEDS-1:0] pattern;
  logic              restart;
  logic [15:0]       tick_count;
  logic [31:0]       ctrl_wr;
  logic [31:0]       period_wr;
  logic [31:0]       pattern_wr;
  logic [31:0]       rd_mux;
  logic              unused_ok;

  assign unused_ok = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr, s_axil_araddr,
                       ctrl_wr, pattern_wr};

  assign s_axil_awready = ~axil_rst & ~aw_held & ~s_axil_bvalid;
  assign s_axil_wready  = ~axil_rst & ~w_held & ~s_axil_bvalid;
  assign s_axil_arready = ~axil_rst & ~s_axil_rvalid;
  assign s_axil_bresp   = RESP_OKAY;
  assign s_axil_rresp   = RESP_OKAY;

  assign aw_hs = s_axil_awvalid & s_axil_awready;
  assign w_hs  = s_axil_wvalid & s_axil_wready;
  assign ar_hs = s_axil_arvalid & s_axil_arready;

  // A write completes on the edge where both address and data are available.
  assign wr_fire = (aw_held | aw_hs) & (w_held | w_hs) & ~s_axil_bvalid;
  assign wr_idx  = aw_held ? aw_idx : reg_idx_t'(s_axil_awaddr[3:2]);
  assign wr_data = w_held ? wdata_q : s_axil_wdata;
  assign wr_strb = w_held ? wstrb_q : s_axil_wstrb;

  // Byte-lane merged candidates for each writable register.
  always_comb begin
    ctrl_wr    = apply_wstrb({30'd0, mode, en}, wr_data, wr_strb);
    period_wr  = apply_wstrb(period, wr_data, wr_strb);
    pattern_wr = apply_wstrb(32'(pattern), wr_data, wr_strb);
  end

  // Write address/data capture and response handshake.
  always_ff @(posedge pl_sys_clk or posedge axil_rst) begin
    if (axil_rst) begin
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_idx        <= REG_CTRL;
      wdata_q       <= 32'd0;
      wstrb_q       <= 4'd0;
      s_axil_bvalid <= 1'b0;
    end else if (s_axil_bvalid && s_axil_bready) begin
      s_axil_bvalid <= 1'b0;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_idx  <= reg_idx_t'(s_axil_awaddr[3:2]);
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wdata_q <= s_axil_wdata;
        wstrb_q <= s_axil_wstrb;
      end
      if (wr_fire) begin
        s_axil_bvalid <= 1'b1;
      end
    end
  end

  // Register file; restart tells the engine to reload after a config change.
  always_ff @(posedge pl_sys_clk or posedge axil_rst) begin
    if (axil_rst) begin
      en      <= 1'b0;
      mode    <= MODE_BLINK;
      period  <= DEFAULT_PERIOD;
      pattern <= {N_LEDS{1'b1}};
      restart <= 1'b0;
    end else if (wr_fire) begin
      case (wr_idx)
        REG_CTRL: begin
          en      <= ctrl_wr[CTRL_EN];
          mode    <= ctrl_wr[CTRL_MODE];
          restart <= ctrl_wr[CTRL_EN];
        end
        REG_PERIOD: begin
          period  <= period_wr;
          restart <= en;
        end
        REG_PATTERN: begin
          pattern <= pattern_wr[N_LEDS-1:0];
          restart <= en;
        end
        default: restart <= 1'b0;
      endcase
    end else begin
      restart <= 1'b0;
    end
  end

  // Read data selection from current register state.
  always_comb begin
    rd_mux = 32'd0;
    case (reg_idx_t'(s_axil_araddr[3:2]))
      REG_CTRL:    rd_mux = {30'd0, mode, en};
      REG_PERIOD:  rd_mux = period;
      REG_PATTERN: rd_mux = 32'(pattern);
      REG_STATUS: begin
        rd_mux        = 32'(leds);
        rd_mux[31:16] = tick_count;
      end
      default:     rd_mux = 32'd0;
    endcase
  end

  // Read response register.
  always_ff @(posedge pl_sys_clk or posedge axil_rst) begin
    if (axil_rst) begin
      s_axil_rvalid <= 1'b0;
      s_axil_rdata  <= 32'd0;
    end else if (ar_hs) begin
      s_axil_rvalid <= 1'b1;
      s_axil_rdata  <= rd_mux;
    end else if (s_axil_rvalid && s_axil_rready) begin
      s_axil_rvalid <= 1'b0;
    end
  end

  led_tick_engine #(
    .N_LEDS(N_LEDS)
  ) u_engine (
    .clk        (pl_sys_clk),
    .rst        (axil_rst),
    .en         (en),
    .mode       (mode),
    .period     (period),
    .pattern    (pattern),
    .restart    (restart),
    .leds       (leds),
    .tick_count (tick_count)
  );

endmodule

// File: tb/tb_axil_led_ctrl.sv
// Directed bench for axil_led_ctrl: register access, byte lanes, channel
// ordering, blink/rotate sequences and reset behaviour.
module tb_axil_led_ctrl;

  logic        clk;
  logic        rst;
  logic [39:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [39:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [7:0]  leds;

  int n_checks = 0;
  int n_pass   = 0;

  axil_led_ctrl #(
    .N_LEDS(8),
    .ADDR_WIDTH(40),
    .DEFAULT_PERIOD(32'd50_000_000)
  ) dut (
    .pl_sys_clk     (clk),
    .axil_rst       (rst),
    .s_axil_awaddr  (awaddr),
    .s_axil_awprot  (awprot),
    .s_axil_awvalid (awvalid),
    .s_axil_awready (awready),
    .s_axil_wdata   (wdata),
    .s_axil_wstrb   (wstrb),
    .s_axil_wvalid  (wvalid),
    .s_axil_wready  (wready),
    .s_axil_bresp   (bresp),
    .s_axil_bvalid  (bvalid),
    .s_axil_bready  (bready),
    .s_axil_araddr  (araddr),
    .s_axil_arprot  (arprot),
    .s_axil_arvalid (arvalid),
    .s_axil_arready (arready),
    .s_axil_rdata   (rdata),
    .s_axil_rresp   (rresp),
    .s_axil_rvalid  (rvalid),
    .s_axil_rready  (rready),
    .leds           (leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic axil_write(input logic [39:0] a, input logic [31:0] d, input logic [3:0] s);
    int  n;
    bit  ad;
    bit  wd;
    n  = 0;
    ad = 1'b0;
    wd = 1'b0;
    @(negedge clk);
    awaddr  = a;
    awvalid = 1'b1;
    wdata   = d;
    wstrb   = s;
    wvalid  = 1'b1;
    while (!(ad && wd) && n < 20) begin
      if (awvalid && awready) ad = 1'b1;
      if (wvalid && wready) wd = 1'b1;
      @(posedge clk);
      n++;
      @(negedge clk);
      if (ad) awvalid = 1'b0;
      if (wd) wvalid = 1'b0;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check("wr_accept", {31'd0, ad && wd}, 32'd1);
    n = 0;
    while (!bvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wr_bvalid", {31'd0, bvalid}, 32'd1);
    check("wr_bresp", {30'd0, bresp}, 32'd0);
    bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axil_read(input logic [39:0] a, output logic [31:0] d);
    int n;
    n = 0;
    @(negedge clk);
    araddr  = a;
    arvalid = 1'b1;
    while (!arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rd_rvalid", {31'd0, rvalid}, 32'd1);
    check("rd_rresp", {30'd0, rresp}, 32'd0);
    d = rdata;
    rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rready = 1'b0;
  endtask

  logic [31:0] rd;
  logic [7:0]  blink_exp[12];
  logic [7:0]  rot_exp[8];
  logic [7:0]  p0_exp[4];

  initial begin
    blink_exp = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00,
                  8'hA5, 8'hA5, 8'hA5, 8'hA5};
    rot_exp   = '{8'h81, 8'h81, 8'h03, 8'h03, 8'h06, 8'h06, 8'h0C, 8'h0C};
    p0_exp    = '{8'hFF, 8'h00, 8'hFF, 8'h00};

    rst = 1'b1;
    awaddr = 40'd0; awprot = 3'd0; awvalid = 1'b0;
    wdata = 32'd0; wstrb = 4'd0; wvalid = 1'b0; bready = 1'b0;
    araddr = 40'd0; arprot = 3'd0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_leds", {24'd0, leds}, 32'd0);
    check("rst_bvalid", {31'd0, bvalid}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_readies", {29'd0, awready, wready, arready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_readies", {29'd0, awready, wready, arready}, 32'd7);

    axil_read(40'h4, rd);  check("def_period", rd, 32'd50_000_000);
    axil_read(40'h8, rd);  check("def_pattern", rd, 32'h0000_00FF);
    axil_read(40'h0, rd);  check("def_ctrl", rd, 32'd0);

    // Byte-lane write and read-only STATUS.
    axil_write(40'h4, 32'h0000_0010, 4'h1);
    axil_read(40'h4, rd);  check("wstrb_period", rd, 32'h02FA_F010);
    axil_write(40'hC, 32'hFFFF_FFFF, 4'hF);
    axil_read(40'h0, rd);  check("status_wr_ctrl", rd, 32'd0);
    axil_read(40'h8, rd);  check("status_wr_pattern", rd, 32'h0000_00FF);
    axil_read(40'hC, rd);  check("status_wr_status", rd, 32'd0);

    // AW three cycles ahead of W, response stalled by bready.
    @(negedge clk);
    awaddr = 40'h8; awvalid = 1'b1; bready = 1'b0;
    check("skew_awready", {31'd0, awready}, 32'd1);
    @(posedge clk); @(negedge clk);
    check("skew_aw_held", {31'd0, awready}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); @(negedge clk);
      check("skew_no_reaccept", {30'd0, awready, bvalid}, 32'd0);
    end
    awvalid = 1'b0;
    wdata = 32'h0000_003C; wstrb = 4'hF; wvalid = 1'b1;
    check("skew_wready", {31'd0, wready}, 32'd1);
    @(posedge clk); @(negedge clk);
    wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("skew_bvalid_hold", {29'd0, bvalid, awready, wready}, 32'd4);
      @(posedge clk); @(negedge clk);
    end
    bready = 1'b1;
    @(posedge clk); @(negedge clk);
    bready = 1'b0;
    check("skew_bvalid_clear", {31'd0, bvalid}, 32'd0);
    axil_read(40'h8, rd);  check("skew_pattern", rd, 32'h0000_003C);

    // Blink: PERIOD 4, PATTERN A5.
    axil_write(40'h4, 32'd4, 4'hF);
    axil_write(40'h8, 32'h0000_00A5, 4'hF);
    axil_write(40'h0, 32'h0000_0001, 4'hF);
    for (int k = 0; k < 12; k++) begin
      check($sformatf("blink_%0d", k), {24'd0, leds}, {24'd0, blink_exp[k]});
      @(negedge clk);
    end

    // Rotate: restart on each write, final PERIOD 2, PATTERN 81.
    axil_write(40'h0, 32'h0000_0003, 4'hF);
    axil_write(40'h8, 32'h0000_0081, 4'hF);
    axil_write(40'h4, 32'd2, 4'hF);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("rotate_%0d", k), {24'd0, leds}, {24'd0, rot_exp[k]});
      @(negedge clk);
    end
    axil_write(40'h0, 32'h0000_0000, 4'hF);
    check("disable_leds", {24'd0, leds}, 32'd0);

    // Reset with a pending write response, a pending read and LEDs lit.
    axil_write(40'h4, 32'd100, 4'hF);
    axil_write(40'h0, 32'h0000_0001, 4'hF);
    @(negedge clk);
    awaddr = 40'hC; awvalid = 1'b1; wdata = 32'd0; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("pre_rst_bvalid", {31'd0, bvalid}, 32'd1);
    araddr = 40'h0; arvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    arvalid = 1'b0;
    check("pre_rst_rvalid", {31'd0, rvalid}, 32'd1);
    check("pre_rst_leds", {24'd0, leds}, 32'h0000_0081);
    rst = 1'b1;
    #1;
    check("mid_rst_outs", {22'd0, leds, bvalid, rvalid}, 32'd0);
    check("mid_rst_readies", {29'd0, awready, wready, arready}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_bvalid", {31'd0, bvalid}, 32'd0);
    axil_read(40'h0, rd);  check("post_rst_ctrl", rd, 32'd0);
    axil_read(40'h4, rd);  check("post_rst_period", rd, 32'd50_000_000);
    axil_read(40'h8, rd);  check("post_rst_pattern", rd, 32'h0000_00FF);

    // PERIOD 0 behaves as 1; tick count holds once disabled.
    axil_write(40'h4, 32'd0, 4'hF);
    axil_write(40'h0, 32'h0000_0001, 4'hF);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("period0_%0d", k), {24'd0, leds}, {24'd0, p0_exp[k]});
      if (k < 3) @(negedge clk);
    end
    axil_write(40'h0, 32'h0000_0000, 4'hF);
    axil_read(40'hC, rd);  check("tick_count_hold", rd, 32'h0005_0000);
    axil_read(40'hC, rd);  check("tick_count_hold2", rd, 32'h0005_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
